// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared constants and helpers for the K=4, rate-1/2
//               hard-decision Viterbi decoder (generators 1011 / 1111).
// Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    localparam int NUM_STATES = 8;

    // Generator taps ordered {u, p1, p2, p3}
    localparam logic [3:0] G1 = 4'b1011;
    localparam logic [3:0] G0 = 4'b1111;

    // Symbol the encoder would emit leaving 'state' = {p1,p2,p3} on input 'u'
    function automatic logic [1:0] exp_sym(input logic [2:0] state, input logic u);
        logic [3:0] w_reg;
        w_reg = {u, state};
        return {^(w_reg & G1), ^(w_reg & G0)};
    endfunction

    // Hamming distance between two 2-bit symbols (0..2)
    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] w_diff;
        w_diff = a ^ b;
        return {1'b0, w_diff[1]} + {1'b0, w_diff[0]};
    endfunction

endpackage : viterbi_pkg
`default_nettype wire

// File: rtl/viterbi_decode_acs.sv
`default_nettype none
// ============================================================================
// Module      : vit_acs
// Description : Add-compare-select cell for one trellis state. Picks the
//               better of two candidate metrics and appends the decided bit
//               to the winning predecessor's survivor path.
// Revision    : 1.0 - initial release
// ============================================================================
module vit_acs #(
    parameter int PM_W     = 6,
    parameter int TB_DEPTH = 16
) (
    input  logic [PM_W:0]       i_cand0,
    input  logic [PM_W:0]       i_cand1,
    input  logic [TB_DEPTH-2:0] i_path0,
    input  logic [TB_DEPTH-2:0] i_path1,
    input  logic                i_dec_bit,
    output logic [PM_W:0]       o_metric,
    output logic [TB_DEPTH-1:0] o_path
);

    logic w_take1;

    // Lower metric wins; a tie keeps the predecessor whose oldest bit is 0
    always_comb begin
        w_take1  = (i_cand1 < i_cand0);
        o_metric = w_take1 ? i_cand1 : i_cand0;
        o_path   = {(w_take1 ? i_path1 : i_path0), i_dec_bit};
    end

endmodule : vit_acs
`default_nettype wire

// File: rtl/viterbi_decode.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_decode
// Description : Hard-decision register-exchange Viterbi decoder, K=4,
//               rate 1/2. One symbol in per en_p strobe, one decoded bit
//               out per strobe once the survivor paths are full.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_decode
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6,
    parameter int INIT_PM  = 8
) (
    input  logic       clk_sig,
    input  logic       rst,
    input  logic       start_p,
    input  logic [1:0] code_sig,
    input  logic       en_p,
    output logic       decode_sig,
    output logic       dec_valid
);

    localparam int              CNT_W      = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0] c_pm_max   = '1;
    localparam logic [PM_W-1:0] c_init_pm  = PM_W'(INIT_PM);
    localparam logic [CNT_W-1:0] c_fill_full = CNT_W'(TB_DEPTH);

    logic [PM_W-1:0]     r_pm       [NUM_STATES];
    logic [TB_DEPTH-1:0] r_path     [NUM_STATES];
    logic [CNT_W-1:0]    r_fill_cnt;
    logic                r_upd_q;
    logic                r_decode;
    logic                r_valid;

    logic [PM_W:0]       w_new_pm   [NUM_STATES];
    logic [TB_DEPTH-1:0] w_new_path [NUM_STATES];
    logic [PM_W:0]       w_diff     [NUM_STATES];
    logic [PM_W-1:0]     w_norm_pm  [NUM_STATES];
    logic [PM_W:0]       w_min;
    logic [2:0]          w_best;
    logic                w_found;

    // One ACS cell per destination state; predecessors differ only in bit 0
    for (genvar n = 0; n < NUM_STATES; n++) begin : g_state
        localparam logic [2:0] c_state = 3'(n);
        localparam logic [2:0] c_pred0 = {c_state[1:0], 1'b0};
        localparam logic [2:0] c_pred1 = {c_state[1:0], 1'b1};

        logic [1:0]    w_bm0;
        logic [1:0]    w_bm1;
        logic [PM_W:0] w_cand0;
        logic [PM_W:0] w_cand1;

        assign w_bm0   = hamming2(code_sig, exp_sym(c_pred0, c_state[2]));
        assign w_bm1   = hamming2(code_sig, exp_sym(c_pred1, c_state[2]));
        assign w_cand0 = {1'b0, r_pm[c_pred0]} + {{(PM_W-1){1'b0}}, w_bm0};
        assign w_cand1 = {1'b0, r_pm[c_pred1]} + {{(PM_W-1){1'b0}}, w_bm1};

        vit_acs #(
            .PM_W     (PM_W),
            .TB_DEPTH (TB_DEPTH)
        ) u_acs (
            .i_cand0   (w_cand0),
            .i_cand1   (w_cand1),
            .i_path0   (r_path[c_pred0][TB_DEPTH-2:0]),
            .i_path1   (r_path[c_pred1][TB_DEPTH-2:0]),
            .i_dec_bit (c_state[2]),
            .o_metric  (w_new_pm[n]),
            .o_path    (w_new_path[n])
        );
    end

    // Smallest of the freshly selected metrics
    always_comb begin
        w_min = w_new_pm[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (w_new_pm[i] < w_min) begin
                w_min = w_new_pm[i];
            end
        end
    end

    // Rebase metrics so the best is zero, then clamp into PM_W bits
    always_comb begin
        for (int i = 0; i < NUM_STATES; i++) begin
            w_diff[i]    = w_new_pm[i] - w_min;
            w_norm_pm[i] = (w_diff[i] > {1'b0, c_pm_max}) ? c_pm_max : w_diff[i][PM_W-1:0];
        end
    end

    // Lowest-index state holding the zero metric is the survivor to read out
    always_comb begin
        w_best  = 3'd0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (!w_found && (r_pm[i] == '0)) begin
                w_best  = 3'(i);
                w_found = 1'b1;
            end
        end
    end

    // Trellis update: metrics, survivor paths and fill counter
    always_ff @(posedge clk_sig or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : c_init_pm;
                r_path[i] <= '0;
            end
            r_fill_cnt <= '0;
            r_upd_q    <= 1'b0;
        end else if (start_p) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : c_init_pm;
                r_path[i] <= '0;
            end
            r_fill_cnt <= '0;
            r_upd_q    <= 1'b0;
        end else if (en_p) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                r_pm[i]   <= w_norm_pm[i];
                r_path[i] <= w_new_path[i];
            end
            if (r_fill_cnt != c_fill_full) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            r_upd_q <= 1'b1;
        end else begin
            r_upd_q <= 1'b0;
        end
    end

    // Output stage: emit the oldest bit of the best survivor one edge after an update
    always_ff @(posedge clk_sig or posedge rst) begin
        if (rst) begin
            r_decode <= 1'b0;
            r_valid  <= 1'b0;
        end else if (start_p) begin
            r_decode <= 1'b0;
            r_valid  <= 1'b0;
        end else if (r_upd_q) begin
            r_decode <= r_path[w_best][TB_DEPTH-1];
            r_valid  <= (r_fill_cnt == c_fill_full);
        end else begin
            r_valid  <= 1'b0;
        end
    end

    assign decode_sig = r_decode;
    assign dec_valid  = r_valid;

endmodule : viterbi_decode
`default_nettype wire

// File: tb/tb_viterbi_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_viterbi_decode
// Description : Self-checking bench for viterbi_decode. A full-history
//               Viterbi model predicts every decoded bit and its cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_decode;

    localparam int TBD    = 16;
    localparam int PMW    = 6;
    localparam int INITPM = 8;
    localparam int PMMAX  = (1 << PMW) - 1;

    logic       clk_sig  = 1'b0;
    logic       rst      = 1'b1;
    logic       start_p  = 1'b0;
    logic [1:0] code_sig = 2'b00;
    logic       en_p     = 1'b0;
    logic       decode_sig;
    logic       dec_valid;

    viterbi_decode #(
        .TB_DEPTH (TBD),
        .PM_W     (PMW),
        .INIT_PM  (INITPM)
    ) dut (
        .clk_sig    (clk_sig),
        .rst        (rst),
        .start_p    (start_p),
        .code_sig   (code_sig),
        .en_p       (en_p),
        .decode_sig (decode_sig),
        .dec_valid  (dec_valid)
    );

    always #5 clk_sig = ~clk_sig;

    int cyc = 0;
    always @(posedge clk_sig) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: full-history Viterbi ----------------
    typedef struct {int due; bit b;} exp_t;
    exp_t       exp_q[$];
    bit         got_q[$];
    bit         ref_q[$];
    int         m_pm[8];
    bit [511:0] m_hist[8];
    int         m_len;
    bit [2:0]   e_st;
    bit         tx_bits[$];
    bit         data_bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};

    function automatic bit [1:0] code_of(input bit u, input bit [2:0] st);
        bit [3:0] r4;
        r4 = {u, st};
        return {^(r4 & 4'b1011), ^(r4 & 4'b1111)};
    endfunction

    function automatic void model_init();
        for (int i = 0; i < 8; i++) m_pm[i] = (i == 0) ? 0 : INITPM;
        m_len = 0;
    endfunction

    task automatic model_step(input bit [1:0] s, input int due);
        int         np[8];
        bit [511:0] nh[8];
        int         mn;
        int         best;
        for (int n = 0; n < 8; n++) begin
            int c[2];
            int p[2];
            bit u;
            u = (n >= 4);
            for (int b = 0; b < 2; b++) begin
                bit [1:0] e;
                p[b] = ((n % 4) * 2) + b;
                e    = code_of(u, 3'(p[b]));
                c[b] = m_pm[p[b]] + int'(e[1] != s[1]) + int'(e[0] != s[0]);
            end
            if (c[1] < c[0]) begin np[n] = c[1]; nh[n] = m_hist[p[1]]; end
            else             begin np[n] = c[0]; nh[n] = m_hist[p[0]]; end
            nh[n][m_len] = u;
        end
        mn = np[0];
        for (int n = 1; n < 8; n++) if (np[n] < mn) mn = np[n];
        for (int n = 0; n < 8; n++) begin
            m_pm[n]   = (np[n] - mn > PMMAX) ? PMMAX : np[n] - mn;
            m_hist[n] = nh[n];
        end
        m_len++;
        if (m_len >= TBD) begin
            best = -1;
            for (int n = 7; n >= 0; n--) if (m_pm[n] == 0) best = n;
            exp_q.push_back('{due, m_hist[best][m_len-TBD]});
        end
    endtask

    task automatic check_pm(input string tag);
        int mn;
        mn = 1 << 30;
        for (int i = 0; i < 8; i++) begin
            chk(tag, 32'(dut.r_pm[i]), 32'(m_pm[i]));
            if (int'(dut.r_pm[i]) < mn) mn = int'(dut.r_pm[i]);
        end
        chk({tag, "_min"}, 32'(mn), 32'd0);
    endtask

    // Output monitor: every negedge either an expected pulse or silence
    always @(negedge clk_sig) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("dec_valid_pulse", 32'(dec_valid), 32'd1);
            chk("decode_sig", 32'(decode_sig), 32'(exp_q[0].b));
            got_q.push_back(decode_sig);
            void'(exp_q.pop_front());
        end else begin
            chk("dec_valid_idle", 32'(dec_valid), 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input bit [1:0] s, input int gap);
        code_sig = s;
        en_p     = 1'b1;
        @(posedge clk_sig); #1;
        en_p     = 1'b0;
        code_sig = 2'($urandom);
        model_step(s, cyc + 1);
        check_pm("pm");
        repeat (gap) begin @(posedge clk_sig); #1; end
    endtask

    task automatic do_start();
        start_p = 1'b1;
        @(posedge clk_sig); #1;
        start_p = 1'b0;
        model_init();
        exp_q.delete();
        got_q.delete();
        e_st = 3'd0;
    endtask

    task automatic enc_send(input bit u, input int gap, input bit flip);
        bit [1:0] s;
        s    = code_of(u, e_st);
        e_st = {u, e_st[2:1]};
        if (flip) s[1] = ~s[1];
        send(s, gap);
    endtask

    task automatic run_frame(input int gap, input int err1, input int err2);
        got_q.delete();
        e_st = 3'd0;
        for (int i = 0; i < tx_bits.size(); i++) enc_send(tx_bits[i], gap, (i == err1) || (i == err2));
        repeat (3) begin @(posedge clk_sig); #1; end
    endtask

    task automatic check_known(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'd11);
        for (int i = 0; i < got_q.size(); i++)
            chk(tag, 32'(got_q[i]), 32'((i < 8) ? data_bits[i] : 1'b0));
    endtask

    initial begin
        // Reset state
        model_init();
        repeat (2) @(posedge clk_sig);
        #1;
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_decode_sig", 32'(decode_sig), 32'd0);
        check_pm("rst_pm");
        rst = 1'b0;
        @(posedge clk_sig); #1;

        // Error-free impulse: 1 then 18 zeros
        do_start();
        tx_bits.delete();
        tx_bits.push_back(1'b1);
        repeat (18) tx_bits.push_back(1'b0);
        run_frame(0, -1, -1);
        chk("impulse_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < got_q.size(); i++) chk("impulse_bit", 32'(got_q[i]), 32'((i == 0) ? 1 : 0));

        // Known sequence back-to-back
        tx_bits.delete();
        for (int i = 0; i < 8; i++) tx_bits.push_back(data_bits[i]);
        repeat (18) tx_bits.push_back(1'b0);
        do_start();
        run_frame(0, -1, -1);
        check_known("known_b2b");
        ref_q = got_q;

        // Same stream with a strobe every 5th cycle
        do_start();
        run_frame(4, -1, -1);
        check_known("known_gap");
        chk("gap_count", 32'(got_q.size()), 32'(ref_q.size()));
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            chk("gap_vs_b2b", 32'(got_q[i]), 32'(ref_q[i]));

        // Single channel error, then two well-separated errors
        do_start();
        run_frame(0, 2, -1);
        check_known("one_err");
        do_start();
        run_frame(1, 2, 15);
        check_known("two_err");

        // Asynchronous reset in the middle of output flow
        do_start();
        for (int i = 0; i < 20; i++) enc_send(tx_bits[i], 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_dec_valid", 32'(dec_valid), 32'd0);
        chk("midrst_decode_sig", 32'(decode_sig), 32'd0);
        exp_q.delete();
        model_init();
        check_pm("midrst_pm");
        @(posedge clk_sig); #1;
        rst = 1'b0;
        got_q.delete();
        e_st = 3'd0;
        for (int i = 0; i < 15; i++) enc_send(tx_bits[i], 0, 1'b0);
        repeat (2) begin @(posedge clk_sig); #1; end
        chk("midrst_no_early_out", 32'(got_q.size()), 32'd0);
        enc_send(tx_bits[15], 0, 1'b0);
        repeat (2) begin @(posedge clk_sig); #1; end
        chk("midrst_first_out", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("midrst_first_bit", 32'(got_q[0]), 32'd1);

        // start_p together with en_p: symbol dropped, pending output suppressed
        do_start();
        for (int i = 0; i < 20; i++) enc_send(tx_bits[i], 0, 1'b0);
        code_sig = 2'b11;
        en_p     = 1'b1;
        start_p  = 1'b1;
        @(posedge clk_sig); #1;
        en_p     = 1'b0;
        start_p  = 1'b0;
        exp_q.delete();
        model_init();
        chk("start_en_dec_valid", 32'(dec_valid), 32'd0);
        check_pm("start_en_pm");
        run_frame(0, -1, -1);
        check_known("after_start_en");

        // Random symbols: metric bounds and full model comparison
        do_start();
        for (int i = 0; i < 200; i++) send(2'($urandom), int'($urandom_range(0, 2)));
        repeat (3) begin @(posedge clk_sig); #1; end
        chk("random_out_count", 32'(got_q.size()), 32'(200 - TBD + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_viterbi_decode
`default_nettype wire
